// File: rtl/stepper_step_gen.sv
// ---------------------------------------------------------------------------
// stepper_step_gen
//
// Step/direction pulse generator. The processor loads a signed step count
// and a half-period (in clocks) and strobes cmd_valid. The block then runs
// the move on its own and drives the JA Pmod header.
//
// Parameters:
//   DIR_SETUP : clocks between a DIR change and the first STEP rising edge
//   MIN_HALF  : smallest half-period allowed; smaller requests are clamped
//
// Ports:
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   cmd_steps   in   signed step count (sign selects direction)
//   cmd_half    in   unsigned half-period in clocks
//   cmd_valid   in   command strobe, taken only while cmd_ready is high
//   cmd_ready   out  high only while idle
//   abort       in   stop the move in progress
//   JA          out  [0] STEP, [1] DIR (1 = negative), [2] EN, [3] BUSY,
//                    [4] DONE pulse, [5] ABORTED flag
//   steps_left  out  remaining steps of the current move
//
// Build option:
//   STEPPER_RAMP_EN : linear acceleration. The first step uses 4*H, each
//                     following step shortens by max(H>>2, 1), floor H.
//                     Left undefined, every step uses H and no ramp logic
//                     is built.
// ---------------------------------------------------------------------------
module stepper_step_gen #(
    parameter int unsigned DIR_SETUP = 4,
    parameter int unsigned MIN_HALF  = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] cmd_steps,
    input  logic [31:0] cmd_half,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        abort,
    output logic [5:0]  JA,
    output logic [31:0] steps_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_e;

    localparam logic [31:0] SETUP_LAST = (DIR_SETUP == 0) ? 32'd0 : 32'(DIR_SETUP - 1);
    localparam logic [31:0] MIN_HALF_W = 32'(MIN_HALF);

    state_e      state_q, state_d;
    logic [31:0] phase_q, phase_d;   // counts down from (hold length - 1) to 0
    logic [31:0] steps_q, steps_d;
    logic [31:0] half_q, half_d;     // clamped base half-period H
    logic        dir_q, dir_d;
    logic        aborted_q, aborted_d;
    logic        step_q, en_q, done_q, ready_q;

    logic        accept;
    logic [31:0] mag;                // |cmd_steps|; -2^31 maps to 2^31
    logic [31:0] cmd_h;              // max(cmd_half, MIN_HALF)
    logic [31:0] cur_half;           // half-period of the step in progress
    logic [31:0] first_half;         // half-period of the first step
    logic [31:0] next_half;          // half-period of the step after this one

    assign accept = cmd_valid && ready_q;
    assign mag    = cmd_steps[31] ? (~cmd_steps + 32'd1) : cmd_steps;
    assign cmd_h  = (cmd_half < MIN_HALF_W) ? MIN_HALF_W : cmd_half;

`ifdef STEPPER_RAMP_EN
    logic [31:0] cur_q, cur_d;
    logic [31:0] ramp_dec;
    logic [33:0] start_wide;

    // 4*H saturates rather than wrapping for absurdly long half-periods.
    assign start_wide = {cmd_h, 2'b00};
    assign first_half = (start_wide[33:32] != 2'b00) ? 32'hFFFF_FFFF : start_wide[31:0];
    assign ramp_dec   = (half_q[31:2] == 30'd0) ? 32'd1 : {2'b00, half_q[31:2]};
    // Compare in 33 bits so H + dec cannot overflow; never undershoot H.
    assign next_half  = ({1'b0, cur_q} > ({1'b0, half_q} + {1'b0, ramp_dec}))
                      ? (cur_q - ramp_dec) : half_q;
    assign cur_half   = cur_q;
`else
    assign first_half = cmd_h;
    assign next_half  = half_q;
    assign cur_half   = half_q;
`endif

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no
        // path through the case leaves one unassigned and no latch appears.
        state_d   = state_q;
        phase_d   = phase_q;
        steps_d   = steps_q;
        half_d    = half_q;
        dir_d     = dir_q;
        aborted_d = aborted_q;
`ifdef STEPPER_RAMP_EN
        cur_d     = cur_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dir_d     = cmd_steps[31];
                    aborted_d = 1'b0;
                    steps_d   = mag;
                    half_d    = cmd_h;
`ifdef STEPPER_RAMP_EN
                    cur_d     = first_half;
`endif
                    if (mag == 32'd0) begin
                        state_d = S_DONE;
                    end else if (DIR_SETUP == 0) begin
                        state_d = S_HIGH;
                        phase_d = first_half - 32'd1;
                    end else begin
                        state_d = S_SETUP;
                        phase_d = SETUP_LAST;
                    end
                end
            end
            S_SETUP: begin
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (phase_q == 32'd0) begin
                    state_d = S_HIGH;
                    phase_d = cur_half - 32'd1;
                end else begin
                    phase_d = phase_q - 32'd1;
                end
            end
            S_HIGH: begin
                // Abort wins over the HIGH->LOW edge: the count stays frozen.
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (phase_q == 32'd0) begin
                    state_d = S_LOW;
                    phase_d = cur_half - 32'd1;
                    steps_d = (steps_q != 32'd0) ? (steps_q - 32'd1) : 32'd0;
                end else begin
                    phase_d = phase_q - 32'd1;
                end
            end
            S_LOW: begin
                // A move that completes on this edge is not reported as
                // aborted, even if abort arrives at the same time.
                if ((phase_q == 32'd0) && (steps_q == 32'd0)) begin
                    state_d = S_DONE;
                end else if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (phase_q == 32'd0) begin
                    state_d = S_HIGH;
                    phase_d = next_half - 32'd1;
`ifdef STEPPER_RAMP_EN
                    cur_d   = next_half;
`endif
                end else begin
                    phase_d = phase_q - 32'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered with it, so JA
    // and cmd_ready change exactly on the edge that changes the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            phase_q   <= 32'd0;
            steps_q   <= 32'd0;
            half_q    <= 32'd0;
            dir_q     <= 1'b0;
            aborted_q <= 1'b0;
            step_q    <= 1'b0;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef STEPPER_RAMP_EN
            cur_q     <= 32'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // the values from before this edge regardless of statement order.
            state_q   <= state_d;
            phase_q   <= phase_d;
            steps_q   <= steps_d;
            half_q    <= half_d;
            dir_q     <= dir_d;
            aborted_q <= aborted_d;
            step_q    <= (state_d == S_HIGH);
            en_q      <= (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_LOW);
            done_q    <= (state_d == S_DONE);
            ready_q   <= (state_d == S_IDLE);
`ifdef STEPPER_RAMP_EN
            cur_q     <= cur_d;
`endif
        end
    end

    // EN and BUSY are the same condition and share one register.
    assign JA         = {aborted_q, done_q, en_q, en_q, dir_q, step_q};
    assign cmd_ready  = ready_q;
    assign steps_left = steps_q;

endmodule

// File: tb/tb_stepper_step_gen.sv
// ---------------------------------------------------------------------------
// tb_stepper_step_gen
//
// Directed and random motion commands for stepper_step_gen. Expected outputs
// for every cycle of a move come from a timeline model: the move is a setup
// gap followed by a list of (high, low) half-periods, and the expected state
// at cycle k after accept is found by walking that list.
// ---------------------------------------------------------------------------
module tb_stepper_step_gen;

    localparam int unsigned D    = 4;
    localparam int unsigned MINH = 2;
`ifdef STEPPER_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    typedef struct packed {
        logic        step;
        logic        busy;
        logic        done;
        logic        ready;
        logic        aborted;
        logic [31:0] left;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cmd_steps = 32'd0;
    logic [31:0] cmd_half = 32'd0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        abort = 1'b0;
    logic [5:0]  JA;
    logic [31:0] steps_left;

    int n_assert = 0;
    int n_fail   = 0;

    // Model of the move in progress.
    longint m_mag;
    longint m_h;
    longint m_abort_k;
    longint m_total;
    bit     m_abort_eff;
    bit     m_dir = 1'b0;

    stepper_step_gen #(
        .DIR_SETUP (D),
        .MIN_HALF  (MINH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd_steps  (cmd_steps),
        .cmd_half   (cmd_half),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .abort      (abort),
        .JA         (JA),
        .steps_left (steps_left)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Half-period of step i of the current move.
    function automatic longint half_of(longint i);
        longint dec;
        longint v;
        if (!RAMP) return m_h;
        dec = ((m_h >> 2) > 0) ? (m_h >> 2) : 64'sd1;
        v = 4 * m_h - i * dec;
        return (v < m_h) ? m_h : v;
    endfunction

    // Cycles from accept to DONE for an uninterrupted move (capped).
    function automatic longint total_cycles();
        longint t;
        t = D;
        for (longint i = 0; i < m_mag; i++) begin
            t += 2 * half_of(i);
            if (t > 100000) break;
        end
        return t;
    endfunction

    // State k edges after the accept edge (k = 0 is just after accept),
    // ignoring abort.
    function automatic exp_t natural_at(longint k);
        exp_t   e;
        longint j;
        longint hh;
        e = '0;
        if (m_mag == 0) begin
            if (k == 0) e.done = 1'b1;
            else        e.ready = 1'b1;
            return e;
        end
        if (k < D) begin
            e.busy = 1'b1;
            e.left = 32'(m_mag);
            return e;
        end
        j = k - D;
        for (longint i = 0; i < m_mag; i++) begin
            hh = half_of(i);
            if (j < hh) begin
                e.busy = 1'b1;
                e.step = 1'b1;
                e.left = 32'(m_mag - i);
                return e;
            end
            j -= hh;
            if (j < hh) begin
                e.busy = 1'b1;
                e.left = 32'(m_mag - i - 1);
                return e;
            end
            j -= hh;
        end
        if (j == 0) e.done = 1'b1;
        else        e.ready = 1'b1;
        return e;
    endfunction

    function automatic exp_t exp_at(longint k);
        exp_t e;
        if (m_abort_eff && (k > m_abort_k)) begin
            e = natural_at(m_abort_k);
            e.step    = 1'b0;
            e.busy    = 1'b0;
            e.aborted = 1'b1;
            e.done    = (k == m_abort_k + 1);
            e.ready   = (k != m_abort_k + 1);
            return e;
        end
        return natural_at(k);
    endfunction

    // Issue one command and check every cycle until one cycle after DONE.
    // abort_sel: -1 none, -2 random cycle, -3 on the final LOW cycle,
    //            -4 inside the 4th HIGH, >= 0 that cycle index.
    // poke: pulse cmd_valid with junk while busy. reset_k: pull reset there.
    task automatic run_cmd(input string name, input logic [31:0] steps, input logic [31:0] half,
                           input int abort_sel, input bit poke, input int reset_k);
        logic [31:0] mg;
        longint      done_k;
        exp_t        e;
        mg        = steps[31] ? (32'd0 - steps) : steps;
        m_mag     = {32'd0, mg};
        m_h       = (half < MINH) ? longint'(MINH) : {32'd0, half};
        m_dir     = steps[31];
        m_total   = (m_mag == 0) ? 0 : total_cycles();
        case (abort_sel)
            -2:      m_abort_k = $urandom_range(0, int'(m_total));
            -3:      m_abort_k = m_total - 1;
            -4:      m_abort_k = D + 2 * (half_of(0) + half_of(1) + half_of(2)) + 1;
            default: m_abort_k = abort_sel;
        endcase
        m_abort_eff = (m_mag != 0) && (m_abort_k >= 0) && (m_abort_k <= m_total - 2);
        done_k      = m_abort_eff ? (m_abort_k + 1) : m_total;

        cmd_steps = steps;
        cmd_half  = half;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_steps = $urandom;
        cmd_half  = $urandom;
        for (longint k = 0; k <= done_k + 1; k++) begin
            e = exp_at(k);
            chk($sformatf("%s k=%0d JA", name, k), {26'd0, JA},
                {26'd0, e.aborted, e.done, e.busy, e.busy, m_dir, e.step});
            chk($sformatf("%s k=%0d steps_left", name, k), steps_left, e.left);
            chk($sformatf("%s k=%0d cmd_ready", name, k), {31'd0, cmd_ready}, {31'd0, e.ready});
            if (k == reset_k) begin
                #2 reset_n = 1'b0;
                #1;
                chk({name, " async JA"}, {26'd0, JA}, 32'd0);
                chk({name, " async steps_left"}, steps_left, 32'd0);
                @(negedge clock);
                reset_n = 1'b1;
                #1;
                chk({name, " released cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
                m_dir = 1'b0;
                return;
            end
            // Abort is also held through DONE and IDLE, where it must be ignored.
            abort     = (k == m_abort_k) || (k >= done_k);
            cmd_valid = poke && (k == 1) && (done_k >= 1);
            if (cmd_valid) begin
                cmd_steps = $urandom;
                cmd_half  = $urandom_range(0, 3);
            end
            @(negedge clock);
        end
        abort     = 1'b0;
        cmd_valid = 1'b0;
    endtask

    initial begin
        // Reset held for three cycles.
        repeat (3) @(posedge clock);
        #1;
        chk("reset JA", {26'd0, JA}, 32'd0);
        chk("reset steps_left", steps_left, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset JA after release", {26'd0, JA}, 32'd0);

        run_cmd("basic",       32'd3,           32'd5, -1, 1'b0, -1);
        run_cmd("negative",    -32'sd2,         32'd1, -1, 1'b0, -1);
        run_cmd("zero",        32'd0,           32'd3, -1, 1'b0, -1);
        run_cmd("busy_poke",   32'd2,           32'd3, -1, 1'b1, -1);
        run_cmd("abort_4th",   32'd10,          32'd3, -4, 1'b0, -1);
        run_cmd("abort_final", 32'd2,           32'd2, -3, 1'b0, -1);
        run_cmd("abort_setup", -32'sd4,         32'd2,  1, 1'b0, -1);
        run_cmd("extreme",     32'h8000_0000,   32'd2,  2, 1'b0, -1);
        run_cmd("reset_mid",   32'd5,           32'd4, -1, 1'b0,  5);
        run_cmd("ramp",        32'd14,          32'd8, -1, 1'b0, -1);

        for (int i = 0; i < 24; i++) begin
            int          s;
            logic [31:0] h;
            int          sel;
            bit          pk;
            s   = int'($urandom_range(0, 12)) - 6;
            h   = $urandom_range(0, 6);
            sel = ($urandom_range(0, 2) == 0) ? -2 : -1;
            pk  = 1'($urandom_range(0, 1));
            run_cmd($sformatf("rand%0d", i), 32'(s), h, sel, pk, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
